// File: rtl/spi_shift_engine_if.sv
// Host-side register/flag bus of the SPI shift engine.
// The engine uses the slave modport; the host or status stage uses master.
interface spi_shift_engine_if;
    logic       SENDER_WRITE;
    logic [7:0] SENDER_DATA;
    logic       RECEIVER_READ;
    logic [7:0] RECEIVER_DATA;
    logic       SENDER_REG_FULL;
    logic       SENDER_REG_EMPTY;
    logic       RECEIVER_REG_FULL;
    logic       RECEIVER_REG_EMPTY;
    logic       BUSY;
    logic       OVERRUN;

    modport master (
        output SENDER_WRITE, SENDER_DATA, RECEIVER_READ,
        input  RECEIVER_DATA, SENDER_REG_FULL, SENDER_REG_EMPTY,
               RECEIVER_REG_FULL, RECEIVER_REG_EMPTY, BUSY, OVERRUN
    );

    modport slave (
        input  SENDER_WRITE, SENDER_DATA, RECEIVER_READ,
        output RECEIVER_DATA, SENDER_REG_FULL, SENDER_REG_EMPTY,
               RECEIVER_REG_FULL, RECEIVER_REG_EMPTY, BUSY, OVERRUN
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 MSB-first master: one-byte sender/receiver registers and a full-duplex shifter.
// Define SPI_LOOPBACK_EN to sample the outgoing MOSI bit instead of MISO.
module spi_shift_engine #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic                S_CLK,
    input  logic                CLR,
    spi_shift_engine_if.slave   bus,
    output logic                SCLK,
    output logic                MOSI,
    input  logic                MISO,
    output logic                CS_N
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_EDGE  = 5'(2 * DATA_W - 1);

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   snd_reg, tx_sr, rx_sr, rx_data;
    logic                snd_full, rx_full, overrun, busy;
    logic                sclk, mosi, cs_n;
    logic [7:0]          div_cnt;
    logic [4:0]          edge_cnt;
    logic                tick, sample_bit;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = MISO;
    assign sample_bit  = mosi;
`else
    assign sample_bit  = MISO;
`endif

    assign tick = (div_cnt == 8'd0);

    always_ff @(posedge S_CLK or posedge CLR) begin
        if (CLR) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (snd_full) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (tick && edge_cnt == LAST_EDGE) state_nxt = DONE;
            DONE:    state_nxt = snd_full ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge S_CLK or posedge CLR) begin
        if (CLR) begin
            snd_reg  <= '0;
            snd_full <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_full  <= 1'b0;
            overrun  <= 1'b0;
            busy     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            div_cnt  <= 8'd0;
            edge_cnt <= 5'd0;
        end else begin
            // LOAD consumes the byte; the still-set flag blocks a same-cycle write
            if (state == LOAD)
                snd_full <= 1'b0;
            else if (bus.SENDER_WRITE && !snd_full) begin
                snd_reg  <= bus.SENDER_DATA;
                snd_full <= 1'b1;
            end

            if (state == DONE) begin
                if (!rx_full || bus.RECEIVER_READ) begin
                    rx_data <= rx_sr;
                    rx_full <= 1'b1;
                    if (bus.RECEIVER_READ) overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (bus.RECEIVER_READ && rx_full) begin
                rx_full <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b0;
                end
                LOAD: begin
                    tx_sr    <= snd_reg;
                    mosi     <= snd_reg[DATA_W-1];
                    cs_n     <= 1'b0;
                    div_cnt  <= DIV_RELOAD;
                    edge_cnt <= 5'd0;
                    busy     <= 1'b1;
                end
                SHIFT: begin
                    if (tick) begin
                        div_cnt  <= DIV_RELOAD;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 5'd1;
                        // sclk low now means this toggle is the rising edge
                        if (!sclk)
                            rx_sr <= {rx_sr[DATA_W-2:0], sample_bit};
                        else begin
                            tx_sr <= tx_sr << 1;
                            mosi  <= tx_sr[DATA_W-2];
                        end
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                DONE: begin
                    cs_n <= 1'b1;
                    if (!snd_full) busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign SCLK                   = sclk;
    assign MOSI                   = mosi;
    assign CS_N                   = cs_n;
    assign bus.RECEIVER_DATA      = rx_data;
    assign bus.SENDER_REG_FULL    = snd_full;
    assign bus.SENDER_REG_EMPTY   = ~snd_full;
    assign bus.RECEIVER_REG_FULL  = rx_full;
    assign bus.RECEIVER_REG_EMPTY = ~rx_full;
    assign bus.BUSY               = busy;
    assign bus.OVERRUN            = overrun;
endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: expected MOSI and received bytes are queued at
// stimulus time and checked by independent monitors; a mode-0 slave model drives MISO.
module tb_spi_shift_engine;
    localparam int CLK_DIV = 2;

    logic S_CLK = 1'b0;
    logic CLR   = 1'b1;
    logic SCLK, MOSI, CS_N;
    logic MISO  = 1'b0;
    logic rd_auto = 1'b0, rd_man = 1'b0;
    bit   auto_rd = 1'b1;

    spi_shift_engine_if bus();
    assign bus.RECEIVER_READ = rd_auto | rd_man;

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) dut (
        .S_CLK (S_CLK),
        .CLR   (CLR),
        .bus   (bus),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .MISO  (MISO),
        .CS_N  (CS_N)
    );

    always #5 S_CLK = ~S_CLK;

    int n_vec = 0, n_err = 0;
    logic [7:0] tx_q[$], rx_q[$], slv_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame sends tx MSB first and receives the slave byte (or tx in loopback)
    task automatic expect_frame(input logic [7:0] tx, input logic [7:0] slv);
        tx_q.push_back(tx);
        slv_q.push_back(slv);
`ifdef SPI_LOOPBACK_EN
        rx_q.push_back(tx);
`else
        rx_q.push_back(slv);
`endif
    endtask

    // Caller sits at a negedge; strobe is sampled on the next posedge
    task automatic send(input logic [7:0] d);
        bus.SENDER_DATA  = d;
        bus.SENDER_WRITE = 1'b1;
        @(negedge S_CLK);
        bus.SENDER_WRITE = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge S_CLK);
    endtask

    task automatic wait_cs_low(input string name);
        int i;
        for (i = 0; i < 200 && CS_N; i++) @(negedge S_CLK);
        chk(name, {31'd0, ~CS_N}, 32'd1);
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 600; i++) begin
            if (!bus.BUSY && CS_N && !bus.SENDER_REG_FULL && !bus.RECEIVER_REG_FULL &&
                !rd_auto && tx_q.size() == 0 && rx_q.size() == 0) break;
            @(negedge S_CLK);
        end
        chk(name, {31'd0, (i < 600)}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rxdata"},  {24'd0, bus.RECEIVER_DATA}, 32'h00);
        chk({tag, "_sfull"},   {31'd0, bus.SENDER_REG_FULL}, 32'd0);
        chk({tag, "_sempty"},  {31'd0, bus.SENDER_REG_EMPTY}, 32'd1);
        chk({tag, "_rfull"},   {31'd0, bus.RECEIVER_REG_FULL}, 32'd0);
        chk({tag, "_rempty"},  {31'd0, bus.RECEIVER_REG_EMPTY}, 32'd1);
        chk({tag, "_busy"},    {31'd0, bus.BUSY}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, bus.OVERRUN}, 32'd0);
        chk({tag, "_sclk"},    {31'd0, SCLK}, 32'd0);
        chk({tag, "_mosi"},    {31'd0, MOSI}, 32'd0);
        chk({tag, "_cs_n"},    {31'd0, CS_N}, 32'd1);
    endtask

    // Mode-0 slave: bit presented before each rising edge, advanced on each falling edge
    initial begin
        logic [7:0] cur;
        forever begin
            @(negedge CS_N);
            cur = (slv_q.size() != 0) ? slv_q.pop_front() : 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
                MISO = cur[i];
                @(negedge SCLK or posedge CS_N);
                if (CS_N) break;
            end
        end
    end

    // MOSI monitor: collect the bit on every SCLK rise, compare each completed byte
    initial begin
        logic [7:0] bits;
        logic       sclk_prev;
        int         nb;
        nb = 0; bits = '0; sclk_prev = 1'b0;
        forever begin
            @(negedge S_CLK);
            if (CLR) begin
                nb = 0;
            end else if (SCLK && !sclk_prev) begin
                bits = {bits[6:0], MOSI};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (tx_q.size() != 0) chk("mosi_byte", {24'd0, bits}, {24'd0, tx_q.pop_front()});
                    else chk("mosi_unexpected_frame", {24'd0, bits}, 32'hFFFF_FFFF);
                end
            end
            sclk_prev = SCLK;
        end
    end

    // Receiver monitor: pop and compare whenever the engine presents a full receiver
    initial begin
        forever begin
            @(negedge S_CLK);
            if (rd_auto) rd_auto = 1'b0;
            else if (auto_rd && !CLR && bus.RECEIVER_REG_FULL) begin
                if (rx_q.size() != 0) chk("rx_data", {24'd0, bus.RECEIVER_DATA}, {24'd0, rx_q.pop_front()});
                else chk("rx_unexpected", {24'd0, bus.RECEIVER_DATA}, 32'hFFFF_FFFF);
                chk("rx_overrun_clear", {31'd0, bus.OVERRUN}, 32'd0);
                rd_auto = 1'b1;
            end
        end
    end

    // Complement flags must track every cycle
    initial begin
        forever begin
            @(negedge S_CLK);
            chk("sender_empty_inv", {31'd0, bus.SENDER_REG_EMPTY}, {31'd0, ~bus.SENDER_REG_FULL});
            chk("receiver_empty_inv", {31'd0, bus.RECEIVER_REG_EMPTY}, {31'd0, ~bus.RECEIVER_REG_FULL});
        end
    end

    initial begin
        int cnt, first_rise, hi, busy_low, toggles;
        logic prev, done;
        logic [7:0] a, b, e;
        bus.SENDER_WRITE = 1'b0;
        bus.SENDER_DATA  = '0;

        // Reset held from time 0
        cycles(3);
        check_reset_state("reset");
        CLR = 1'b0;
        cycles(2);

        // Single frame 0xA5 / slave 0x3C with latency checks
        expect_frame(8'hA5, 8'h3C);
        send(8'hA5);
        for (cnt = 0; cnt < 50 && CS_N; cnt++) @(negedge S_CLK);
        chk("write_to_cs_low", cnt, 2);
        first_rise = -1;
        done = 1'b0;
        for (cnt = 1; cnt < 200; cnt++) begin
            @(negedge S_CLK);
            if (SCLK && first_rise < 0) first_rise = cnt;
            if (bus.RECEIVER_REG_FULL) begin done = 1'b1; break; end
        end
        chk("cs_to_first_rise", first_rise, CLK_DIV);
        chk("cs_to_rx_full", done ? cnt : -1, 16 * CLK_DIV + 1);
        drain("drain_single");

        // Back-to-back 0x11 then 0x22
        expect_frame(8'h11, 8'($urandom));
        send(8'h11);
        wait_cs_low("b2b_first_start");
        cycles(5);
        expect_frame(8'h22, 8'($urandom));
        send(8'h22);
        busy_low = 0;
        for (cnt = 0; cnt < 200 && !CS_N; cnt++) begin
            if (!bus.BUSY) busy_low++;
            @(negedge S_CLK);
        end
        for (hi = 0; hi < 50 && CS_N; hi++) begin
            if (!bus.BUSY) busy_low++;
            @(negedge S_CLK);
        end
        chk("b2b_cs_high_cycles", hi, 1);
        chk("b2b_busy_drops", busy_low, 0);
        drain("drain_b2b");

        // Write while full: second write is dropped
        expect_frame(8'h55, 8'($urandom));
        send(8'h55);
        send(8'h66);
        chk("wwf_sender_full", {31'd0, bus.SENDER_REG_FULL}, 32'd1);
        drain("drain_wwf");
        cycles(6);
        chk("wwf_single_frame", {30'd0, bus.BUSY, CS_N}, 32'd1);

        // Overrun: two frames with no read
        auto_rd = 1'b0;
        expect_frame(8'h01, 8'($urandom));
        send(8'h01);
        wait_cs_low("ovr_first_start");
        cycles(3);
        expect_frame(8'h02, 8'($urandom));
        send(8'h02);
        for (cnt = 0; cnt < 300; cnt++) begin
            if (tx_q.size() == 0 && !bus.BUSY && CS_N) break;
            @(negedge S_CLK);
        end
        chk("ovr_frames_done", {31'd0, (cnt < 300)}, 32'd1);
        cycles(2);
        e = rx_q.pop_front();
        void'(rx_q.pop_front());
        chk("ovr_rx_data", {24'd0, bus.RECEIVER_DATA}, {24'd0, e});
        chk("ovr_flag", {31'd0, bus.OVERRUN}, 32'd1);
        chk("ovr_rx_full", {31'd0, bus.RECEIVER_REG_FULL}, 32'd1);
        rd_man = 1'b1;
        @(negedge S_CLK);
        rd_man = 1'b0;
        chk("ovr_read_clears_full", {31'd0, bus.RECEIVER_REG_FULL}, 32'd0);
        chk("ovr_read_clears_flag", {31'd0, bus.OVERRUN}, 32'd0);
        auto_rd = 1'b1;
        cycles(2);

        // Reset mid-frame after the fifth SCLK toggle
        expect_frame(8'($urandom), 8'($urandom));
        send(tx_q[tx_q.size() - 1]);
        wait_cs_low("mid_reset_start");
        toggles = 0;
        prev = SCLK;
        for (cnt = 0; cnt < 200 && toggles < 5; cnt++) begin
            @(negedge S_CLK);
            if (SCLK !== prev) toggles++;
            prev = SCLK;
        end
        chk("mid_reset_toggles", toggles, 5);
        CLR = 1'b1;
        #1;
        chk("mid_reset_sclk", {31'd0, SCLK}, 32'd0);
        chk("mid_reset_cs_n", {31'd0, CS_N}, 32'd1);
        chk("mid_reset_busy", {31'd0, bus.BUSY}, 32'd0);
        void'(tx_q.pop_back());
        void'(rx_q.pop_back());
        cycles(2);
        CLR = 1'b0;
        cycles(40);
        chk("mid_reset_rx_full", {31'd0, bus.RECEIVER_REG_FULL}, 32'd0);

        // Randomised frames, occasional back-to-back and dropped writes
        for (int n = 0; n < 24; n++) begin
            a = 8'($urandom);
            expect_frame(a, 8'($urandom));
            send(a);
            if ($urandom_range(0, 2) == 0) send(~a);
            if ($urandom_range(0, 1) == 1) begin
                wait_cs_low("rand_start");
                cycles($urandom_range(0, 20));
                b = 8'($urandom);
                expect_frame(b, 8'($urandom));
                send(b);
            end
            drain("drain_rand");
            cycles($urandom_range(0, 4));
        end

        // Reset mid-idle with a non-zero byte left in the receiver register
        expect_frame(8'h80, 8'hC3);
        send(8'h80);
        drain("drain_pre_reset");
        CLR = 1'b1;
        cycles(3);
        check_reset_state("idle_reset");
        CLR = 1'b0;
        cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

SPI master transfer engine (mode 0, MSB first) for the SPI interface. It holds one byte for transmit and one byte for receive, and shifts a full-duplex frame on SCLK/MOSI/MISO/CS_N. It sits directly upstream of the status-combination stage and produces the four register flags (SENDER/RECEIVER × FULL/EMPTY) that the status stage folds into its STATUS byte.

## Interface
Parameters:
- CLK_DIV, 4, S_CLK cycles per SCLK half-period; legal range 1..255.
- DATA_W, 8, frame width; fixed at 8, not to be overridden.

Ports:
- S_CLK  in  1  system clock; all state changes on its rising edge.
- CLR  in  1  reset; asynchronous, active-high.
- SENDER_WRITE  in  1  one-cycle strobe that writes SENDER_DATA into the sender register.
- SENDER_DATA  in  8  byte to transmit.
- RECEIVER_READ  in  1  one-cycle strobe that pops the receiver register.
- RECEIVER_DATA  out  8  last received byte; valid while RECEIVER_REG_FULL=1.
- SENDER_REG_FULL  out  1  sender register holds an unsent byte.
- SENDER_REG_EMPTY  out  1  always the inverse of SENDER_REG_FULL.
- RECEIVER_REG_FULL  out  1  receiver register holds an unread byte.
- RECEIVER_REG_EMPTY  out  1  always the inverse of RECEIVER_REG_FULL.
- BUSY  out  1  high from LOAD through DONE inclusive.
- OVERRUN  out  1  sticky flag: a frame completed while the receiver register was full.
- SCLK  out  1  SPI clock; idles low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- CS_N  out  1  chip select, active low.

## Operation
- All outputs are registered.
- Reset values: RECEIVER_DATA=0x00, SENDER_REG_FULL=0, SENDER_REG_EMPTY=1, RECEIVER_REG_FULL=0, RECEIVER_REG_EMPTY=1, BUSY=0, OVERRUN=0, SCLK=0, MOSI=0, CS_N=1. FSM resets to IDLE, divider counter to 0, edge counter to 0.
- Sender write:
  - Accepted only when the registered SENDER_REG_EMPTY=1. Data is latched and SENDER_REG_FULL is set on the next edge.
  - A write while full is silently ignored and the stored byte is unchanged.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - CS_N=1, SCLK=0.
  - Moves to LOAD when SENDER_REG_FULL=1.
- LOAD (1 cycle):
  - Shift register takes the sender register, and SENDER_REG_FULL clears.
  - CS_N goes to 0, MOSI takes bit 7, divider loads CLK_DIV-1, edge counter goes to 0, BUSY goes to 1.
  - A SENDER_WRITE in the LOAD cycle is ignored, because the flag is still full.
- SHIFT:
  - The divider decrements each cycle. At 0 it reloads, SCLK toggles, and the edge counter increments.
  - On a rising toggle, the sampled bit shifts into the LSB of the receive shift register.
  - On a falling toggle, MOSI takes the next transmit bit.
  - After the 16th toggle (SCLK back at 0) the FSM moves to DONE.
- DONE (1 cycle):
  - CS_N=1.
  - The received byte is committed to the receiver register:
    - Receiver empty, or RECEIVER_READ active this same cycle: store the byte and set RECEIVER_REG_FULL=1.
    - Receiver full and no read: discard the new byte, set OVERRUN=1, and leave RECEIVER_DATA unchanged.
  - Next state is LOAD if SENDER_REG_FULL=1, otherwise IDLE (which drops BUSY).
- RECEIVER_READ:
  - When full: clears RECEIVER_REG_FULL and OVERRUN next edge.
  - When empty: no effect.
- Reset mid-frame: every register returns to its reset value immediately. The partial frame is lost and no flag reflects it.

## Timing
- Taking the LOAD cycle as cycle 0:
  - SCLK toggles at cycles k·CLK_DIV for k=1..16.
  - The first toggle is rising, so CS_N-to-first-edge setup is CLK_DIV cycles.
  - DONE is at cycle 16·CLK_DIV+1.
  - RECEIVER_REG_FULL is visible at cycle 16·CLK_DIV+2.
- SENDER_WRITE in IDLE → LOAD two cycles later (flag set, then FSM reacts).
- Back-to-back frames: CS_N is high for exactly one cycle (DONE) between frames. Frame period is 16·CLK_DIV+2 cycles.
- MISO is sampled by S_CLK on the cycle SCLK rises; the slave must present the bit before that edge.

## Configuration
- SPI_LOOPBACK_EN defined: the rising-edge sample bit is the current MOSI and MISO is ignored, so each frame receives exactly the byte it sent.
- SPI_LOOPBACK_EN undefined: the sample bit is MISO.
- The MISO port exists in both builds.

## Test plan
- Reset: assert CLR for 3 cycles mid-idle → all outputs equal the listed reset values; SENDER_REG_EMPTY=1, RECEIVER_REG_EMPTY=1.
- Single frame, CLK_DIV=2, no loopback: write 0xA5, slave drives 0x3C → MOSI bits at rising edges are 1,0,1,0,0,1,0,1; RECEIVER_DATA=0x3C; DONE 33 cycles after LOAD.
- Back-to-back: write 0x11, then write 0x22 during the frame → two frames; CS_N high exactly one cycle between them; BUSY stays high throughout.
- Write-while-full: write 0x55 then 0x66 before LOAD → 0x66 ignored and 0x55 transmitted; with SPI_LOOPBACK_EN, RECEIVER_DATA=0x55.
- Overrun: two frames (0x01, 0x02) in loopback with no read → RECEIVER_DATA=0x01, OVERRUN=1; one RECEIVER_READ clears both flags.
- Reset mid-frame: assert CLR after the 5th SCLK toggle → SCLK=0, CS_N=1, BUSY=0 immediately; RECEIVER_REG_FULL stays 0.
